// File: rtl/unary_pkg.sv
// Types and width helpers shared by the unary transmitter, receiver and MAC lanes.
package unary_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_EMIT = 2'd1,
    TX_GAP  = 2'd2
  } unary_tx_state_t;

  function automatic int unsigned u_bits(input int unsigned bin_bits);
    return 32'd1 << bin_bits;
  endfunction

endpackage

// File: rtl/unary_therm_cmp.sv
// One serial lane: registered thermometer compare, high while the frame counter is below the lane value.
module unary_therm_cmp #(
  parameter int BIN_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic [BIN_BITS-1:0] cnt_i,
  input  logic [BIN_BITS:0]   val_i,
  output logic                out_o
);

  logic out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= 1'b0;
    else       out_q <= en_i && ({1'b0, cnt_i} < val_i);
  end

  assign out_o = out_q;

endmodule

// File: rtl/unary_stream_tx.sv
// Binary-to-unary transmitter: one-entry holding register feeding lane-aligned unary frames
// with a frame strobe on cycle 0 and a forced idle gap between frames.
module unary_stream_tx
  import unary_pkg::*;
#(
  parameter int BIN_BITS = 4,
  parameter int LANES    = 3,
  parameter int GAP      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*(BIN_BITS+1)-1:0]   in_data,
  input  logic                            out_ready,
  output logic [LANES-1:0]                out,
  output logic                            frame,
  output logic                            busy,
  output logic                            sat
);

  localparam int VW     = BIN_BITS + 1;
  localparam int U_BITS = int'(u_bits(BIN_BITS));
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [VW-1:0] U_VAL    = VW'(U_BITS);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  if (GAP < 1) begin : g_gap_chk
    $error("unary_stream_tx: GAP must be >= 1");
  end

  unary_tx_state_t state_q, state_d;
  logic [BIN_BITS-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic [LANES-1:0][VW-1:0]    hold_q, val_q, val_d, lane_clamp;
  logic [LANES-1:0]            lane_sat;
  logic                        full_q, load, accept;
  logic                        frame_q, busy_q, sat_q;

  for (genvar i = 0; i < LANES; i++) begin : g_clamp
    assign lane_sat[i]   = in_data[i*VW +: VW] > U_VAL;
    assign lane_clamp[i] = lane_sat[i] ? U_VAL : in_data[i*VW +: VW];
  end

  // A frame load frees the holding slot in the same cycle, so a new operand can land behind it.
  assign in_ready = !full_q || load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    load    = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (full_q && out_ready) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = TX_EMIT;
        end
      end
      TX_EMIT: begin
        if (cnt_q == '1) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = TX_GAP;
        end else begin
          cnt_d = cnt_q + BIN_BITS'(1);
        end
      end
      TX_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (full_q && out_ready) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = TX_EMIT;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign val_d = load ? hold_q : val_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      hold_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (accept) begin
        hold_q <= lane_clamp;
        full_q <= 1'b1;
      end else if (load) begin
        full_q <= 1'b0;
      end
      if (accept && |lane_sat) sat_q <= 1'b1;
    end
  end

  // Outputs are flopped from next-state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      val_q   <= '0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      val_q   <= val_d;
      frame_q <= (state_d == TX_EMIT) && (cnt_d == '0);
      busy_q  <= state_d != TX_IDLE;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    unary_therm_cmp #(.BIN_BITS(BIN_BITS)) u_cmp (
      .clk   (clk),
      .reset (reset),
      .en_i  (state_d == TX_EMIT),
      .cnt_i (cnt_d),
      .val_i (val_d[i]),
      .out_o (out[i])
    );
  end

  assign frame = frame_q;
  assign busy  = busy_q;
  assign sat   = sat_q;

endmodule
